// File: rtl/osc_bank.sv
// osc_bank: multi-voice tone generator.
// Each voice has a divider counter that advances an OUT_W-bit phase counter;
// the phase is decoded to square, saw or triangle and registered per voice.
// A registered adder mixes the samples of all enabled voices.
module osc_bank #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 16,
    parameter int OUT_W      = 8,
    localparam int MIX_W     = (NUM_VOICES > 1) ? OUT_W + $clog2(NUM_VOICES) : OUT_W
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [NUM_VOICES-1:0]       voice_en,
    input  logic [NUM_VOICES*DIV_W-1:0] divider,
    input  logic [NUM_VOICES*2-1:0]     mode,
    output logic [NUM_VOICES*OUT_W-1:0] wave_out,
    output logic [NUM_VOICES-1:0]       cycle_o,
    output logic [MIX_W-1:0]            mix_out
);

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [DIV_W-1:0] count;
        logic [DIV_W-1:0] act_div;
        logic [OUT_W-1:0] phase;
        logic [OUT_W-1:0] tri_ramp;
        logic [OUT_W-1:0] wave_d;
        logic [OUT_W-1:0] wave_q;
        logic             cyc_q;
        logic [DIV_W-1:0] div_in;
        logic [1:0]       mode_v;
        logic             wrap;

        assign div_in = divider[v*DIV_W +: DIV_W];
        assign mode_v = mode[v*2 +: 2];
        // act_div only reloads at a wrap (or while disabled/frozen), so a
        // divider change never cuts the running count short.
        assign wrap   = voice_en[v] && (act_div != '0) && (count >= act_div);

        // Divider and phase counters for this voice
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                count   <= DIV_W'(1);
                phase   <= '0;
                act_div <= '0;
            end else if (!voice_en[v]) begin
                count   <= DIV_W'(1);
                phase   <= '0;
                act_div <= div_in;
            end else if (act_div == '0) begin
                act_div <= div_in;
            end else if (wrap) begin
                count   <= DIV_W'(1);
                phase   <= phase + OUT_W'(1);
                act_div <= div_in;
            end else begin
                count   <= count + DIV_W'(1);
            end
        end

        // Waveform decode of the current phase
        always_comb begin
            tri_ramp = {phase[OUT_W-2:0], 1'b0};
            case (mode_v)
                MODE_SQUARE: wave_d = phase[OUT_W-1] ? '0 : '1;
                MODE_SAW:    wave_d = phase;
                MODE_TRI:    wave_d = phase[OUT_W-1] ? ~tri_ramp : tri_ramp;
                default:     wave_d = '0;
            endcase
            if (!voice_en[v]) begin
                wave_d = '0;
            end
        end

        // Registered sample and phase-wrap pulse
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                wave_q <= '0;
                cyc_q  <= 1'b0;
            end else begin
                wave_q <= wave_d;
                cyc_q  <= wrap && (phase == '1);
            end
        end

        assign wave_out[v*OUT_W +: OUT_W] = wave_q;
        assign cycle_o[v]                 = cyc_q;
    end

    logic [MIX_W-1:0] mix_sum;

    // Sum of the registered samples of enabled voices
    always_comb begin
        mix_sum = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (voice_en[v]) begin
                mix_sum = mix_sum + MIX_W'(wave_out[v*OUT_W +: OUT_W]);
            end
        end
    end

    // Registered mix output
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mix_out <= '0;
        end else begin
            mix_out <= mix_sum;
        end
    end

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: directed checks of osc_bank with 4 voices, 16-bit dividers,
// 8-bit samples. Outputs are sampled on the falling clock edge.
module tb_osc_bank;

    localparam int NV = 4;
    localparam int DW = 16;
    localparam int OW = 8;
    localparam int MW = 10;

    logic             clk;
    logic             nrst;
    logic [NV-1:0]    voice_en;
    logic [NV*DW-1:0] divider;
    logic [NV*2-1:0]  mode;
    logic [NV*OW-1:0] wave_out;
    logic [NV-1:0]    cycle_o;
    logic [MW-1:0]    mix_out;

    int n_checks = 0;
    int n_pass   = 0;

    osc_bank #(
        .NUM_VOICES (NV),
        .DIV_W      (DW),
        .OUT_W      (OW)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .voice_en (voice_en),
        .divider  (divider),
        .mode     (mode),
        .wave_out (wave_out),
        .cycle_o  (cycle_o),
        .mix_out  (mix_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // one rising edge, then park on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_voice(input int v, input logic [DW-1:0] d, input logic [1:0] m);
        divider[v*DW +: DW] = d;
        mode[v*2 +: 2]      = m;
    endtask

    function automatic int sq_ref(input int p);
        return (p % 256) < 128 ? 255 : 0;
    endfunction

    function automatic int tri_ref(input int p);
        int q;
        q = p % 256;
        return q < 128 ? 2 * q : 511 - 2 * q;
    endfunction

    function automatic int w(input int v);
        return int'(wave_out[v*OW +: OW]);
    endfunction

    function automatic int phase4(input int k);
        return k < 20 ? k / 10 : 2 + (k - 20) / 4;
    endfunction

    initial begin
        nrst     = 1'b0;
        voice_en = '0;
        divider  = '0;
        mode     = '0;
        for (int v = 0; v < NV; v++) set_voice(v, 16'd3, 2'd1);
        step();
        step();
        check("reset wave_out", wave_out, 0);
        check("reset cycle_o", cycle_o, 0);
        check("reset mix_out", mix_out, 0);

        // 1: voice0 saw, divider 3
        nrst = 1'b1;
        step();
        voice_en = 4'b0001;
        for (int k = 1; k <= 800; k++) begin
            step();
            check($sformatf("t1 wave0 k=%0d", k), w(0), ((k - 1) / 3) % 256);
            check($sformatf("t1 cyc0 k=%0d", k), cycle_o[0], (k == 768) ? 1 : 0);
            check($sformatf("t1 mix k=%0d", k), mix_out, (k < 2) ? 0 : ((k - 2) / 3) % 256);
            if (k % 100 == 0) check($sformatf("t1 others k=%0d", k), wave_out[NV*OW-1:OW], 0);
        end

        // 2: voice0 square, divider 2
        voice_en = 4'b0000;
        set_voice(0, 16'd2, 2'd0);
        step();
        voice_en = 4'b0001;
        for (int k = 1; k <= 1100; k++) begin
            step();
            check($sformatf("t2 wave0 k=%0d", k), w(0), sq_ref((k - 1) / 2));
            check($sformatf("t2 cyc0 k=%0d", k), cycle_o[0], (k == 512 || k == 1024) ? 1 : 0);
        end

        // 3: voice0 triangle, divider 1
        voice_en = 4'b0000;
        set_voice(0, 16'd1, 2'd2);
        step();
        voice_en = 4'b0001;
        for (int k = 1; k <= 520; k++) begin
            step();
            check($sformatf("t3 wave0 k=%0d", k), w(0), tri_ref(k - 1));
            check($sformatf("t3 cyc0 k=%0d", k), cycle_o[0], (k == 256 || k == 512) ? 1 : 0);
        end

        // 4: divider 10 -> 4 mid-count, saw shows the phase
        voice_en = 4'b0000;
        set_voice(0, 16'd10, 2'd1);
        step();
        voice_en = 4'b0001;
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("t4 wave0 k=%0d", k), w(0), phase4(k - 1));
            if (k == 13) set_voice(0, 16'd4, 2'd1);
        end

        // 5: all voices square, divider 1; then drop voice2
        voice_en = 4'b0000;
        for (int v = 0; v < NV; v++) set_voice(v, 16'd1, 2'd0);
        step();
        voice_en = 4'b1111;
        for (int k = 1; k <= 300; k++) begin
            step();
            check($sformatf("t5 mix k=%0d", k), mix_out, (k < 2) ? 0 : 4 * sq_ref(k - 2));
        end
        voice_en = 4'b1011;
        for (int k = 301; k <= 310; k++) begin
            step();
            check($sformatf("t5 mix3 k=%0d", k), mix_out, 765);
            check($sformatf("t5 wave2 k=%0d", k), w(2), 0);
        end

        // 6: asynchronous reset mid-tone
        check("t6 wave0 before reset", w(0), 255);
        #2;
        nrst = 1'b0;
        #1;
        check("t6 async wave_out", wave_out, 0);
        check("t6 async cycle_o", cycle_o, 0);
        check("t6 async mix_out", mix_out, 0);
        voice_en = 4'b0001;
        set_voice(0, 16'd3, 2'd1);
        step();
        nrst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t6 wave0 k=%0d", k), w(0), (k < 2) ? 0 : (k - 2) / 3);
        end

        // 6b: divider 0 with enable held keeps the voice frozen at phase 0
        nrst = 1'b0;
        set_voice(0, 16'd0, 2'd0);
        step();
        nrst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t6 frozen wave0 k=%0d", k), w(0), 255);
            check($sformatf("t6 frozen cyc0 k=%0d", k), cycle_o[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
